// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register carrying IR, PC+4 and a payload
//            bus with a valid/ready handshake, flush and a 2-entry skid
//            buffer. In_Ready is registered, so there is no combinational
//            path from Out_Ready back to the upstream stage.
//            Optional statistics counters are enabled by defining the
//            macro PIPE_STAGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          IR_W     = 32,
    parameter int          PC_W     = 32,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [IR_W-1:0]   IR_I,
    input  logic [PC_W-1:0]   PC4_I,
    input  logic [DATA_W-1:0] DATA_I,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [IR_W-1:0]   IR_O,
    output logic [PC_W-1:0]   PC4_O,
    output logic [DATA_W-1:0] DATA_O
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       Stall_Cnt,
    output logic [31:0]       Bubble_Cnt,
    output logic [31:0]       Flush_Cnt
`endif
);

    localparam logic [PC_W-1:0] c_pc_reset = PC_W'(PC_RESET);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q,   in_ready_d;
    logic [IR_W-1:0]   main_ir_q,    main_ir_d;
    logic [PC_W-1:0]   main_pc4_q,   main_pc4_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [IR_W-1:0]   skid_ir_q,    skid_ir_d;
    logic [PC_W-1:0]   skid_pc4_q,   skid_pc4_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic emit;

    assign accept = In_Valid & in_ready_q;
    assign emit   = main_valid_q & Out_Ready;

    // Next-state of the two entries: main/skid occupancy drives where an
    // accepted entry lands, and the skid always drains into main first.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_ir_d    = main_ir_q;
        main_pc4_d   = main_pc4_q;
        main_data_d  = main_data_q;
        skid_ir_d    = skid_ir_q;
        skid_pc4_d   = skid_pc4_q;
        skid_data_d  = skid_data_q;

        case ({main_valid_q, skid_valid_q})
            2'b00: begin
                if (accept) begin
                    main_valid_d = 1'b1;
                    main_ir_d    = IR_I;
                    main_pc4_d   = PC4_I;
                    main_data_d  = DATA_I;
                end
            end
            2'b10: begin
                if (accept && emit) begin
                    main_ir_d   = IR_I;
                    main_pc4_d  = PC4_I;
                    main_data_d = DATA_I;
                end else if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_ir_d    = IR_I;
                    skid_pc4_d   = PC4_I;
                    skid_data_d  = DATA_I;
                end else if (emit) begin
                    main_valid_d = 1'b0;
                end
            end
            2'b11: begin
                if (emit) begin
                    skid_valid_d = 1'b0;
                    main_ir_d    = skid_ir_q;
                    main_pc4_d   = skid_pc4_q;
                    main_data_d  = skid_data_q;
                end
            end
            default: begin
                // Skid valid without main valid cannot be reached; drop it.
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase

        // Squash discards both entries and any same-cycle accept.
        if (Flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_ir_d    = '0;
            main_pc4_d   = c_pc_reset;
            main_data_d  = '0;
            skid_ir_d    = '0;
            skid_pc4_d   = '0;
            skid_data_d  = '0;
        end

        in_ready_d = ~skid_valid_d;
    end

    // Entry storage and registered ready; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_ir_q    <= '0;
            main_pc4_q   <= c_pc_reset;
            main_data_q  <= '0;
            skid_ir_q    <= '0;
            skid_pc4_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_ir_q    <= main_ir_d;
            main_pc4_q   <= main_pc4_d;
            main_data_q  <= main_data_d;
            skid_ir_q    <= skid_ir_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign In_Ready  = in_ready_q;
    assign Out_Valid = main_valid_q;
    // An empty stage presents a nop; PC4/DATA keep the last main value.
    assign IR_O      = main_valid_q ? main_ir_q : '0;
    assign PC4_O     = main_pc4_q;
    assign DATA_O    = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    // Event counters; they wrap naturally and survive Flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (main_valid_q && !Out_Ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!main_valid_q) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (Flush && (main_valid_q || skid_valid_q)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared only by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign Stall_Cnt  = stall_cnt_q;
    assign Bubble_Cnt = bubble_cnt_q;
    assign Flush_Cnt  = flush_cnt_q;
`else
    // Statistics disabled: no counter state is built.
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) that replaces the fixed per-stage latch modules.
- Carries IR, PC+4 and a configurable payload bus, with a valid/ready handshake, flush and a 2-entry skid buffer.
- Stalls in later stages back-pressure earlier stages with no combinational ready path and no data loss.

Parameters:
- IR_W, 32, instruction register width
- PC_W, 32, PC+4 field width
- DATA_W, 64, payload width (e.g. {AO, RT} = 64 for EX/MEM)
- PC_RESET, 32'h00003000, PC+4 value at reset and flush (truncated to PC_W)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Flush  in  1  synchronous clear of both entries (branch/exception squash)
- In_Valid  in  1  upstream presents a valid entry
- In_Ready  out  1  stage can accept an entry this cycle
- IR_I  in  IR_W  instruction in
- PC4_I  in  PC_W  PC+4 in
- DATA_I  in  DATA_W  payload in
- Out_Valid  out  1  main entry valid
- Out_Ready  in  1  downstream consumes the main entry this cycle
- IR_O  out  IR_W  instruction out; 0 (nop bubble) whenever Out_Valid=0
- PC4_O  out  PC_W  PC+4 of main entry
- DATA_O  out  DATA_W  payload of main entry

Behaviour:
- Reset and clock: Reset is synchronous, active-high; clock is Clk. Reset has priority over Flush and over all transfers.
- Reset / flush values: both entries invalid, main IR/DATA = 0, main PC4 = PC_RESET, skid contents = 0. Out_Valid=0, In_Ready=1, IR_O=0, PC4_O=PC_RESET, DATA_O=0.
- Transfer definitions: accept = In_Valid & In_Ready; emit = Out_Valid & Out_Ready.
- In_Ready is a registered signal equal to the inverse of skid_valid. It has no combinational path from Out_Ready.
- States (main_valid, skid_valid):
  - EMPTY (0,0): accept loads main, next state ONE.
  - ONE (1,0):
    - accept & emit: main <= input, stay ONE.
    - accept & !emit: skid <= input, next state TWO.
    - emit & !accept: next state EMPTY.
  - TWO (1,1): In_Ready=0, so no accept is possible. emit: main <= skid, next state ONE. No emit: hold.
- Latency: an accepted entry appears on outputs the next cycle. Throughput is 1 entry/cycle while Out_Ready=1.
- Ordering: FIFO order is always preserved; the skid entry never overtakes the main entry.
- Flush: next cycle goes to the reset/flush values above. A same-cycle accept is dropped. A same-cycle emit still counts as consumed downstream.
- Empty-main outputs: PC4_O and DATA_O hold the last main value when the main entry is invalid; only IR_O is forced to 0.
- Fields: all fields are stored verbatim, with no arithmetic on them.
- Assignments: all register updates are nonblocking.
- Simulation: no initial blocks; reset defines all state.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN
- With the macro defined:
  - Adds 32-bit output Stall_Cnt: increments each cycle Out_Valid & !Out_Ready.
  - Adds 32-bit output Bubble_Cnt: increments each cycle !Out_Valid while not in Reset.
  - Adds 32-bit output Flush_Cnt: increments on each Flush with at least one valid entry.
  - All three counters are cleared by Reset only (not by Flush) and wrap from 32'hFFFFFFFF to 0.
- Without the macro: the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset held 2 cycles with In_Valid=1 -> Out_Valid=0, In_Ready=1, IR_O=0, PC4_O=32'h00003000, DATA_O=0; nothing accepted.
- Stream IR=0x11,0x22,0x33 on consecutive cycles with Out_Ready=1 -> each appears 1 cycle later with matching PC4/DATA; In_Ready stays 1.
- Out_Ready=0 while sending 0xA1 then 0xA2 -> state TWO, In_Ready=0 next cycle. Raise Out_Ready -> outputs 0xA1 then 0xA2; In_Ready returns to 1 one cycle after 0xA1 is emitted.
- In state TWO assert Flush with In_Valid=1, IR_I=0xFF -> next cycle Out_Valid=0, IR_O=0, PC4_O=PC_RESET, In_Ready=1; 0xFF is never emitted.
- Reset asserted mid-stream in state TWO -> same values as the power-up check in the first scenario, next cycle.
- With PIPE_STAGE_STATS_EN: 3 stall cycles, 1 flush of a valid entry, 2 idle cycles -> Stall_Cnt=3, Flush_Cnt=1, Bubble_Cnt counts only idle cycles after reset release; Stall_Cnt preset near 32'hFFFFFFFF wraps to 0.
